// File: rtl/dmem_responder.sv
// dmem_responder: single-port word RAM that serves MEM-stage loads/stores over valid/ready.
// Define DMEM_MISALIGN_CHECK_EN to suppress misaligned accesses and raise misalign_err.

`ifndef MEM_SB
`define MEM_SB   3'd0
`endif
`ifndef MEM_SH
`define MEM_SH   3'd1
`endif
`ifndef MEM_SW
`define MEM_SW   3'd2
`endif
`ifndef MEM_LB
`define MEM_LB   3'd3
`endif
`ifndef MEM_LH
`define MEM_LH   3'd4
`endif
`ifndef MEM_LB_U
`define MEM_LB_U 3'd5
`endif
`ifndef MEM_LH_U
`define MEM_LH_U 3'd6
`endif
`ifndef MEM_LW
`define MEM_LW   3'd7
`endif

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        misalign_err
);

    typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic [1:0]        req_b;
    logic              accept, ld_acc, st_acc, mis;
    logic [3:0]        wmask;
    logic [31:0]       wdata_rep;
    logic              unused_addr_hi;

    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] b);
        case (op)
            `MEM_SB: lane_mask = 4'b0001 << b;
            `MEM_SH: lane_mask = b[1] ? 4'b1100 : 4'b0011;
            `MEM_SW: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            `MEM_SB: replicate_wdata = {4{d[7:0]}};
            `MEM_SH: replicate_wdata = {2{d[15:0]}};
            default: replicate_wdata = d;
        endcase
    endfunction

    // Addressed byte/half is shifted to bit 0; sign extension is left to the MEM stage.
    function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] b,
                                              input logic [31:0] word);
        logic [31:0] sh;
        case (op)
            `MEM_LB, `MEM_LB_U: begin
                sh = word >> {b, 3'b000};
                load_data = {24'b0, sh[7:0]};
            end
            `MEM_LH, `MEM_LH_U: begin
                sh = word >> {b[1], 4'b0000};
                load_data = {16'b0, sh[15:0]};
            end
            default: load_data = word;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] b);
        case (op)
            `MEM_SH, `MEM_LH, `MEM_LH_U: misaligned = b[0];
            `MEM_SW, `MEM_LW:            misaligned = |b;
            default:                     misaligned = 1'b0;
        endcase
    endfunction

    assign req_idx        = req_addr[IDX_W+1:2];
    assign req_b          = req_addr[1:0];
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];
    assign accept         = req_valid & req_ready;
    assign ld_acc         = accept & ~req_we;
    assign st_acc         = accept & req_we;
    assign wmask          = lane_mask(req_op, req_b);
    assign wdata_rep      = replicate_wdata(req_op, req_wdata);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;

    assign mis          = misaligned(req_op, req_b);
    assign misalign_err = err_q;

    always_ff @(posedge Clk) begin
        if (!Reset_n) err_q <= 1'b0;
        else          err_q <= accept & mis;
    end
`else
    assign mis          = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_q <= CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = IDLE;
            IDLE:    if (ld_acc) state_d = RESP;
            RESP:    if (rsp_ready) state_d = ld_acc ? RESP : IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // Ready is also gated by Reset_n so nothing can be accepted on a reset edge.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready = Reset_n;
            RESP:    begin
                req_ready = Reset_n & rsp_ready;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clr_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + IDX_W'(1);
            if (ld_acc)           rdata_q   <= mis ? 32'h0 : load_data(req_op, req_b, mem[req_idx]);
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (st_acc && !mis) begin
            for (int i = 0; i < 4; i++)
                if (wmask[i]) mem[req_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=16); follows DMEM_MISALIGN_CHECK_EN if defined.

`ifndef MEM_SB
`define MEM_SB   3'd0
`endif
`ifndef MEM_SH
`define MEM_SH   3'd1
`endif
`ifndef MEM_SW
`define MEM_SW   3'd2
`endif
`ifndef MEM_LB
`define MEM_LB   3'd3
`endif
`ifndef MEM_LH
`define MEM_LH   3'd4
`endif
`ifndef MEM_LB_U
`define MEM_LB_U 3'd5
`endif
`ifndef MEM_LH_U
`define MEM_LH_U 3'd6
`endif
`ifndef MEM_LW
`define MEM_LW   3'd7
`endif

module tb_dmem_responder;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_ERR  = 32'h1;
    localparam logic [31:0] W0_AFTER = 32'h0;
    localparam logic [31:0] LW1_EXP  = 32'h0;
    localparam logic [31:0] LBU3_EXP = 32'h0;
`else
    localparam logic [31:0] MIS_ERR  = 32'h0;
    localparam logic [31:0] W0_AFTER = 32'h1111_1111;
    localparam logic [31:0] LW1_EXP  = 32'h1111_1111;
    localparam logic [31:0] LBU3_EXP = 32'h0000_0011;
`endif

    dmem_responder #(.DEPTH_WORDS(16)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .misalign_err (misalign_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!req_ready && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'h1);
    endtask

    task automatic store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_err);
        req_valid = 1'b1; req_we = 1'b1; req_op = op; req_addr = addr; req_wdata = data;
        wait_ready(8);
        @(negedge Clk);
        req_valid = 1'b0; req_we = 1'b0;
        check({tag, "_err"}, 32'(misalign_err), exp_err);
    endtask

    task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] exp, input logic [31:0] exp_err);
        req_valid = 1'b1; req_we = 1'b0; req_op = op; req_addr = addr;
        wait_ready(8);
        @(negedge Clk);
        req_valid = 1'b0;
        check({tag, "_vld"}, 32'(rsp_valid), 32'h1);
        check({tag, "_data"}, rsp_rdata, exp);
        check({tag, "_err"}, 32'(misalign_err), exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(misalign_err), 32'h0);

        // Clear sweep: 16 cycles of not-ready, then ready.
        Reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clear_ready_%0d", i), 32'(req_ready), 32'h0);
            @(negedge Clk);
        end
        check("clear_done_ready", 32'(req_ready), 32'h1);

        load("clr_lw14", `MEM_LW, 32'h14, 32'h0, 32'h0);
        load("clr_lw3c", `MEM_LW, 32'h3C, 32'h0, 32'h0);

        store("sw8", `MEM_SW, 32'h8, 32'hDEAD_BEEF, 32'h0);
        store("sb9", `MEM_SB, 32'h9, 32'h0000_00A5, 32'h0);
        load("lw8", `MEM_LW, 32'h8, 32'hDEAD_A5EF, 32'h0);
        load("lbu_b", `MEM_LB_U, 32'hB, 32'h0000_00DE, 32'h0);
        load("lb9", `MEM_LB, 32'h9, 32'h0000_00A5, 32'h0);
        load("lhu_a", `MEM_LH_U, 32'hA, 32'h0000_DEAD, 32'h0);

        store("sh6", `MEM_SH, 32'h6, 32'h0000_1234, 32'h0);
        load("lh6", `MEM_LH, 32'h6, 32'h0000_1234, 32'h0);
        load("lh4", `MEM_LH, 32'h4, 32'h0, 32'h0);
        load("lw4", `MEM_LW, 32'h4, 32'h1234_0000, 32'h0);

        store("sw_wrap", `MEM_SW, 32'h50, 32'hCAFE_F00D, 32'h0);
        load("lw_wrap", `MEM_LW, 32'h10, 32'hCAFE_F00D, 32'h0);

        // Back-to-back loads with backpressure on the second response.
        req_valid = 1'b1; req_we = 1'b0; req_op = `MEM_LW; req_addr = 32'h8;
        wait_ready(8);
        @(negedge Clk);
        check("b2b_a_vld", 32'(rsp_valid), 32'h1);
        check("b2b_a_data", rsp_rdata, 32'hDEAD_A5EF);
        req_addr = 32'h4;
        @(negedge Clk);
        check("b2b_b_data", rsp_rdata, 32'h1234_0000);
        rsp_ready = 1'b0;
        req_addr = 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check($sformatf("b2b_hold_vld_%0d", i), 32'(rsp_valid), 32'h1);
            check($sformatf("b2b_hold_data_%0d", i), rsp_rdata, 32'h1234_0000);
            check($sformatf("b2b_hold_ready_%0d", i), 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        req_valid = 1'b0;
        check("b2b_c_vld", 32'(rsp_valid), 32'h1);
        check("b2b_c_data", rsp_rdata, 32'hCAFE_F00D);
        @(negedge Clk);
        check("b2b_drain_vld", 32'(rsp_valid), 32'h0);

        // Alignment handling depends on DMEM_MISALIGN_CHECK_EN.
        store("sw_mis", `MEM_SW, 32'h2, 32'h1111_1111, MIS_ERR);
        load("lw0_after", `MEM_LW, 32'h0, W0_AFTER, 32'h0);
        load("lw_mis", `MEM_LW, 32'h1, LW1_EXP, MIS_ERR);
        load("lbu3", `MEM_LB_U, 32'h3, LBU3_EXP, 32'h0);

        // Reset while a response is stalled in RESP.
        @(negedge Clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_op = `MEM_LW; req_addr = 32'h8;
        wait_ready(8);
        @(negedge Clk);
        req_valid = 1'b0;
        check("mid_vld", 32'(rsp_valid), 32'h1);
        check("mid_data", rsp_rdata, 32'hDEAD_A5EF);
        Reset_n = 1'b0;
        @(negedge Clk);
        check("mid_rst_vld", 32'(rsp_valid), 32'h0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        Reset_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge Clk);
        check("reclear_ready", 32'(req_ready), 32'h0);
        wait_ready(40);
        load("reclr_lw8", `MEM_LW, 32'h8, 32'h0, 32'h0);
        load("reclr_lw4", `MEM_LW, 32'h4, 32'h0, 32'h0);
        load("reclr_lw10", `MEM_LW, 32'h10, 32'h0, 32'h0);
        @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
